// File: rtl/ext_fifo_drain_pkg.sv
// Shared constants, serializer state encoding and byte-lane selection for the
// extraction-FIFO drain.
package riscv_ext_pkg;

    localparam int          DATA_WIDTH       = 32;
    localparam logic [31:0] EXT_FIFO_ADDRESS = 32'h0001_0150;
    localparam int          BYTES_PER_WORD   = 4;
    localparam int          IDX_W            = $clog2(BYTES_PER_WORD);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // Byte idx of a word in transmit order; lsb_first=0 sends bits [31:24] first.
    function automatic logic [7:0] select_byte(input logic [DATA_WIDTH-1:0] word,
                                               input logic [IDX_W-1:0]      idx,
                                               input logic                  lsb_first);
        logic [IDX_W-1:0] lane;
        lane = lsb_first ? idx : (2'd3 - idx);
        case (lane)
            2'd0:    select_byte = word[7:0];
            2'd1:    select_byte = word[15:8];
            2'd2:    select_byte = word[23:16];
            2'd3:    select_byte = word[31:24];
            default: select_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ext_fifo_drain_if.sv
// Processor write port plus host byte stream of the extraction FIFO.
// The master drives the write strobe, READY and OVERFLOW_CLR; the slave is the drain.
interface ext_fifo_drain_if #(parameter int D = 4);
    import riscv_ext_pkg::*;

    logic                  EXT_FIFO_WR_ENB;
    logic [DATA_WIDTH-1:0] EXT_FIFO_WR_DATA;
    logic [7:0]            BYTE_OUT;
    logic                  BYTE_OUT_VALID;
    logic                  BYTE_OUT_READY;
    logic [D:0]            FIFO_COUNT;
    logic                  OVERFLOW;
    logic                  OVERFLOW_CLR;

    modport master (
        output EXT_FIFO_WR_ENB, EXT_FIFO_WR_DATA, BYTE_OUT_READY, OVERFLOW_CLR,
        input  BYTE_OUT, BYTE_OUT_VALID, FIFO_COUNT, OVERFLOW
    );

    modport slave (
        input  EXT_FIFO_WR_ENB, EXT_FIFO_WR_DATA, BYTE_OUT_READY, OVERFLOW_CLR,
        output BYTE_OUT, BYTE_OUT_VALID, FIFO_COUNT, OVERFLOW
    );

endinterface

// File: rtl/ext_fifo_drain_sync_fifo.sv
// 2^D x 32 synchronous FIFO with D+1 bit wrapping pointers and fall-through read data.
// The caller guarantees no push while full and no pop while empty.
module ext_sync_fifo
    import riscv_ext_pkg::*;
#(
    parameter int D = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [D:0]            count
);

    localparam int DEPTH = 32'd1 << D;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [D:0]            wr_ptr_r;
    logic [D:0]            rd_ptr_r;

    // Pointer registers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{D{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{D{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[D-1:0]] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r[D-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[D] != rd_ptr_r[D]) && (wr_ptr_r[D-1:0] == rd_ptr_r[D-1:0]);
    assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/ext_fifo_drain.sv
// Buffers words written by the core to the extraction FIFO and drains them as a
// valid/ready byte stream; the core is never stalled, overflowing writes are dropped.
module ext_fifo_drain
    import riscv_ext_pkg::*;
#(
    parameter int D         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              CLK,
    input logic              RSTN,
    ext_fifo_drain_if.slave  bus
);

    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s;
    logic [D:0]            fifo_count_s;
    logic                  drop_s;

    ser_state_e            state_r;
    ser_state_e            state_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_nxt_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic [7:0]            byte_r;
    logic [7:0]            byte_nxt_s;
    logic                  valid_r;
    logic                  valid_nxt_s;
    logic                  overflow_r;
    logic                  overflow_nxt_s;

    // A pop in the same cycle frees the slot, so a write at full is still accepted then.
    assign fifo_push_s = bus.EXT_FIFO_WR_ENB & (~fifo_full_s | fifo_pop_s);
    assign drop_s      = bus.EXT_FIFO_WR_ENB & fifo_full_s & ~fifo_pop_s;

    ext_sync_fifo #(.D(D)) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (bus.EXT_FIFO_WR_DATA),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    // Serializer next state: load a word from IDLE, step bytes, chain words without a bubble.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        idx_nxt_s   = idx_r;
        byte_nxt_s  = byte_r;
        valid_nxt_s = valid_r;
        fifo_pop_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    shift_nxt_s = fifo_dout_s;
                    idx_nxt_s   = 2'd0;
                    byte_nxt_s  = select_byte(fifo_dout_s, 2'd0, LSB_FIRST);
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (valid_r && bus.BYTE_OUT_READY) begin
                    if (idx_r != 2'd3) begin
                        idx_nxt_s  = idx_r + 2'd1;
                        byte_nxt_s = select_byte(shift_r, idx_r + 2'd1, LSB_FIRST);
                    end else if (!fifo_empty_s) begin
                        fifo_pop_s  = 1'b1;
                        shift_nxt_s = fifo_dout_s;
                        idx_nxt_s   = 2'd0;
                        byte_nxt_s  = select_byte(fifo_dout_s, 2'd0, LSB_FIRST);
                    end else begin
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (bus.OVERFLOW_CLR) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Serializer and overflow state registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            idx_r      <= 2'd0;
            byte_r     <= 8'h00;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            idx_r      <= idx_nxt_s;
            byte_r     <= byte_nxt_s;
            valid_r    <= valid_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign bus.BYTE_OUT       = byte_r;
    assign bus.BYTE_OUT_VALID = valid_r;
    assign bus.FIFO_COUNT     = fifo_count_s;
    assign bus.OVERFLOW       = overflow_r;

endmodule

// File: tb/tb_ext_fifo_drain.sv
// Self-checking bench for ext_fifo_drain (D=4, LSB_FIRST=1): vector table for
// single words, hand sequences for backpressure, overflow, back-to-back and reset.
module tb_ext_fifo_drain;
    import riscv_ext_pkg::*;

    localparam int D = 4;

    typedef struct {
        logic [31:0] word;
        logic [31:0] stream;   // expected bytes in send order, first byte in [31:24]
    } vec_t;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    ext_fifo_drain_if #(.D(D)) bus ();
    ext_fifo_drain #(.D(D), .LSB_FIRST(1'b1)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ramp(input int i);
        return 32'h0302_0100 + 32'h0404_0404 * 32'(i);
    endfunction

    function automatic logic [31:0] to_stream(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] s);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(s[31 - 8*b -: 8]);
        end
    endtask

    // One-cycle write strobe; expected bytes go to the scoreboard only if the word is kept.
    task automatic write_word(input logic [31:0] w, input logic [31:0] s, input bit keep);
        bus.EXT_FIFO_WR_ENB  = 1'b1;
        bus.EXT_FIFO_WR_DATA = w;
        if (keep) push_stream(s);
        tick();
        bus.EXT_FIFO_WR_ENB  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.BYTE_OUT_VALID) && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0 || bus.BYTE_OUT_VALID) begin
            n_err++;
            $display("FAIL drain_timeout: %0d bytes outstanding, valid=%0b", exp_q.size(), bus.BYTE_OUT_VALID);
        end
    endtask

    // Byte scoreboard: every handshake seen half a cycle before its edge is compared in order.
    always @(negedge CLK) begin : mon
        logic [7:0] e;
        if (RSTN && bus.BYTE_OUT_VALID && bus.BYTE_OUT_READY) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_byte: got %0h, expected none", bus.BYTE_OUT);
            end else begin
                e = exp_q.pop_front();
                check("stream_byte", 32'(bus.BYTE_OUT), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int rises;
        logic prev;

        vecs[0] = '{32'h4433_2211, 32'h1122_3344};
        vecs[1] = '{32'hA1B2_C3D4, 32'hD4C3_B2A1};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{32'h8000_0001, 32'h0100_0080};
        vecs[5] = '{32'hDEAD_BEEF, 32'hEFBE_ADDE};

        RSTN                 = 1'b0;
        bus.EXT_FIFO_WR_ENB  = 1'b0;
        bus.EXT_FIFO_WR_DATA = 32'h0;
        bus.BYTE_OUT_READY   = 1'b0;
        bus.OVERFLOW_CLR     = 1'b0;

        // Reset held 3 cycles, write strobed while in reset is ignored.
        repeat (3) tick();
        bus.EXT_FIFO_WR_ENB  = 1'b1;
        bus.EXT_FIFO_WR_DATA = 32'hBAD0_BAD0;
        tick();
        bus.EXT_FIFO_WR_ENB  = 1'b0;
        check("rst_valid", 32'(bus.BYTE_OUT_VALID), 32'd0);
        check("rst_byte",  32'(bus.BYTE_OUT), 32'd0);
        check("rst_count", 32'(bus.FIFO_COUNT), 32'd0);
        check("rst_ovf",   32'(bus.OVERFLOW), 32'd0);
        RSTN = 1'b1;
        tick();
        tick();
        check("post_rst_count", 32'(bus.FIFO_COUNT), 32'd0);
        check("post_rst_valid", 32'(bus.BYTE_OUT_VALID), 32'd0);

        // Table of single words with READY high: 2-cycle latency, 4 bytes, then idle.
        bus.BYTE_OUT_READY = 1'b1;
        for (int v = 0; v < 6; v++) begin
            write_word(vecs[v].word, vecs[v].stream, 1'b1);
            check("lat_valid_k",  32'(bus.BYTE_OUT_VALID), 32'd0);
            check("lat_count_k",  32'(bus.FIFO_COUNT), 32'd1);
            tick();
            check("lat_valid_k1", 32'(bus.BYTE_OUT_VALID), 32'd1);
            check("lat_byte0",    32'(bus.BYTE_OUT), 32'(vecs[v].stream[31:24]));
            check("lat_count_k1", 32'(bus.FIFO_COUNT), 32'd0);
            repeat (4) tick();
            check("end_valid",    32'(bus.BYTE_OUT_VALID), 32'd0);
            check("end_q_empty",  32'(exp_q.size()), 32'd0);
        end

        // Backpressure: first byte held stable with VALID while READY is low.
        bus.BYTE_OUT_READY = 1'b0;
        write_word(32'hA1B2_C3D4, 32'hD4C3_B2A1, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.BYTE_OUT_VALID), 32'd1);
            check("bp_byte",  32'(bus.BYTE_OUT), 32'h0000_00D4);
            tick();
        end
        bus.BYTE_OUT_READY = 1'b1;
        wait_drain(20);

        // Fill: word 0 sits in the serializer, words 1..16 fill all 16 slots.
        bus.BYTE_OUT_READY = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            write_word(ramp(i), to_stream(ramp(i)), 1'b1);
        end
        check("full_count", 32'(bus.FIFO_COUNT), 32'd16);
        check("full_ovf0",  32'(bus.OVERFLOW), 32'd0);
        write_word(ramp(17), 32'h0, 1'b0);
        check("drop_count", 32'(bus.FIFO_COUNT), 32'd16);
        check("drop_ovf",   32'(bus.OVERFLOW), 32'd1);
        bus.OVERFLOW_CLR = 1'b1;
        write_word(ramp(17), 32'h0, 1'b0);
        bus.OVERFLOW_CLR = 1'b0;
        check("clr_vs_drop", 32'(bus.OVERFLOW), 32'd1);
        bus.OVERFLOW_CLR = 1'b1;
        tick();
        bus.OVERFLOW_CLR = 1'b0;
        check("clr_ovf", 32'(bus.OVERFLOW), 32'd0);

        // Write at full on the edge where the serializer pops: accepted, no overflow.
        bus.BYTE_OUT_READY = 1'b1;
        repeat (3) tick();
        write_word(ramp(18), to_stream(ramp(18)), 1'b1);
        check("pushpop_count", 32'(bus.FIFO_COUNT), 32'd16);
        check("pushpop_ovf",   32'(bus.OVERFLOW), 32'd0);
        wait_drain(200);
        check("drained_count", 32'(bus.FIFO_COUNT), 32'd0);

        // Back-to-back words: 12 bytes in one unbroken VALID run.
        vcnt  = 0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) begin
                bus.EXT_FIFO_WR_ENB  = 1'b1;
                bus.EXT_FIFO_WR_DATA = ramp(30 + c);
                push_stream(to_stream(ramp(30 + c)));
            end else begin
                bus.EXT_FIFO_WR_ENB  = 1'b0;
            end
            tick();
            if (bus.BYTE_OUT_VALID) vcnt++;
            if (bus.BYTE_OUT_VALID && !prev) rises++;
            prev = bus.BYTE_OUT_VALID;
        end
        check("b2b_valid_cycles", 32'(vcnt), 32'd12);
        check("b2b_valid_rises",  32'(rises), 32'd1);
        wait_drain(10);

        // Reset mid-drain: two words queued, reset while the third byte is presented.
        write_word(32'h5566_7788, 32'h0, 1'b0);
        write_word(32'h1122_3344, 32'h0, 1'b0);
        exp_q.push_back(8'h88);
        exp_q.push_back(8'h77);
        repeat (2) tick();
        check("mid_byte2",  32'(bus.BYTE_OUT), 32'h0000_0066);
        check("mid_count",  32'(bus.FIFO_COUNT), 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_valid", 32'(bus.BYTE_OUT_VALID), 32'd0);
        check("arst_count", 32'(bus.FIFO_COUNT), 32'd0);
        check("arst_byte",  32'(bus.BYTE_OUT), 32'd0);
        check("arst_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        RSTN = 1'b1;
        tick();
        write_word(32'h0D0C_0B0A, 32'h0A0B_0C0D, 1'b1);
        tick();
        check("rerun_valid", 32'(bus.BYTE_OUT_VALID), 32'd1);
        check("rerun_byte0", 32'(bus.BYTE_OUT), 32'h0000_000A);
        wait_drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
